// File: rtl/digit_serial_addsub.sv
// Digit-serial adder/subtractor: one DIGIT-wide ripple slice plus a carry register
// processes a WIDTH-bit add or subtract over WIDTH/DIGIT cycles.
module digit_serial_addsub #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] s,
  output logic             c_out,
  output logic             ovf
);

  localparam int unsigned NDIG = WIDTH / DIGIT;
  localparam int unsigned CntW = (NDIG > 1) ? $clog2(NDIG) : 1;

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e state_q, state_d;

  logic [WIDTH-1:0] opa_q, opa_d;
  logic [WIDTH-1:0] opb_q, opb_d;
  logic [WIDTH-1:0] work_q, work_d;
  logic [WIDTH-1:0] s_q, s_d;
  logic             carry_q, carry_d;
  logic             c_out_q, c_out_d;
  logic             ovf_q, ovf_d;
  logic [CntW-1:0]  cnt_q, cnt_d;

  logic             accept;
  logic             last;
  logic [31:0]      base;
  logic [DIGIT-1:0] dig_a, dig_b, dig_s;
  logic [DIGIT:0]   rc;

  // Idle and the done cycle both accept a new request.
  assign accept = start && (state_q != StRun);
  assign last   = (cnt_q == CntW'(NDIG - 1));
  assign base   = 32'(cnt_q) * DIGIT;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start) state_d = StRun;
      StRun:   if (last) state_d = StDone;
      StDone:  state_d = start ? StRun : StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    busy = (state_q == StRun);
    done = (state_q == StDone);
  end

  // Ripple slice over the current digit; rc[i] is the carry into bit i of the digit.
  always_comb begin
    dig_a = opa_q[base +: DIGIT];
    dig_b = opb_q[base +: DIGIT];
    dig_s = '0;
    rc    = '0;
    rc[0] = carry_q;
    for (int i = 0; i < DIGIT; i++) begin
      dig_s[i]  = dig_a[i] ^ dig_b[i] ^ rc[i];
      rc[i + 1] = (dig_a[i] & dig_b[i]) | (rc[i] & (dig_a[i] ^ dig_b[i]));
    end
  end

  always_comb begin
    opa_d   = opa_q;
    opb_d   = opb_q;
    work_d  = work_q;
    s_d     = s_q;
    carry_d = carry_q;
    c_out_d = c_out_q;
    ovf_d   = ovf_q;
    cnt_d   = cnt_q;
    if (accept) begin
      // Subtract as a + ~b + ~borrow so the same slice serves both modes.
      opa_d   = a;
      opb_d   = sub ? ~b : b;
      carry_d = sub ? ~c_in : c_in;
      cnt_d   = '0;
    end else if (state_q == StRun) begin
      work_d[base +: DIGIT] = dig_s;
      carry_d = rc[DIGIT];
      cnt_d   = cnt_q + 1'b1;
      if (last) begin
        s_d     = work_d;
        c_out_d = rc[DIGIT];
        ovf_d   = rc[DIGIT-1] ^ rc[DIGIT];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      opa_q   <= '0;
      opb_q   <= '0;
      work_q  <= '0;
      s_q     <= '0;
      carry_q <= 1'b0;
      c_out_q <= 1'b0;
      ovf_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      work_q  <= work_d;
      s_q     <= s_d;
      carry_q <= carry_d;
      c_out_q <= c_out_d;
      ovf_q   <= ovf_d;
      cnt_q   <= cnt_d;
    end
  end

  assign s     = s_q;
  assign c_out = c_out_q;
  assign ovf   = ovf_q;

endmodule

// File: tb/tb_digit_serial_addsub.sv
// Randomised bench for digit_serial_addsub at DIGIT = 1, 4 and 16 against an
// arithmetic reference model.
module tb_digit_serial_addsub;

  logic        clk;
  logic        rst;
  logic        start_r [3];
  logic        sub;
  logic [15:0] a;
  logic [15:0] b;
  logic        c_in;
  logic        busy_w  [3];
  logic        done_w  [3];
  logic [15:0] s_w     [3];
  logic        co_w    [3];
  logic        ov_w    [3];

  int checks;
  int failures;

  digit_serial_addsub #(.WIDTH(16), .DIGIT(1)) u_d1 (
    .clk(clk), .rst(rst), .start(start_r[0]), .sub(sub), .a(a), .b(b), .c_in(c_in),
    .busy(busy_w[0]), .done(done_w[0]), .s(s_w[0]), .c_out(co_w[0]), .ovf(ov_w[0])
  );
  digit_serial_addsub #(.WIDTH(16), .DIGIT(4)) u_d4 (
    .clk(clk), .rst(rst), .start(start_r[1]), .sub(sub), .a(a), .b(b), .c_in(c_in),
    .busy(busy_w[1]), .done(done_w[1]), .s(s_w[1]), .c_out(co_w[1]), .ovf(ov_w[1])
  );
  digit_serial_addsub #(.WIDTH(16), .DIGIT(16)) u_d16 (
    .clk(clk), .rst(rst), .start(start_r[2]), .sub(sub), .a(a), .b(b), .c_in(c_in),
    .busy(busy_w[2]), .done(done_w[2]), .s(s_w[2]), .c_out(co_w[2]), .ovf(ov_w[2])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  function automatic int ndig_of(input int idx);
    return (idx == 0) ? 16 : (idx == 1) ? 4 : 1;
  endfunction

  // Reference: plain integer arithmetic; overflow = signed result out of 16-bit range.
  task automatic model(input logic [15:0] oa, input logic [15:0] ob, input logic oc,
                       input logic os, output logic [15:0] es, output logic eco,
                       output logic eov);
    logic [16:0] u;
    int          sv;
    if (!os) begin
      u   = 17'(oa) + 17'(ob) + 17'(oc);
      eco = u[16];
      sv  = int'($signed(oa)) + int'($signed(ob)) + int'(oc);
    end else begin
      u   = 17'(oa) - 17'(ob) - 17'(oc);
      eco = ~u[16];
      sv  = int'($signed(oa)) - int'($signed(ob)) - int'(oc);
    end
    es  = u[15:0];
    eov = (sv > 32767) || (sv < -32768);
  endtask

  task automatic scramble();
    a    = 16'($urandom);
    b    = 16'($urandom);
    c_in = 1'($urandom_range(0, 1));
    sub  = 1'($urandom_range(0, 1));
  endtask

  // Drive a request on the next falling edge; returns one cycle after acceptance.
  task automatic issue(input int idx, input logic [15:0] oa, input logic [15:0] ob,
                       input logic oc, input logic os);
    @(negedge clk);
    a = oa; b = ob; c_in = oc; sub = os;
    start_r[idx] = 1'b1;
    @(negedge clk);
    start_r[idx] = 1'b0;
    scramble();
  endtask

  // Counts busy cycles until done; returns in the done cycle.
  task automatic wait_done(input int idx, input bit glitch, input logic [15:0] es,
                           input logic eco, input logic eov);
    int n;
    n = 0;
    while (!done_w[idx] && n < 40) begin
      if (busy_w[idx]) n++;
      if (glitch && n == 2) begin
        start_r[idx] = 1'b1;
        scramble();
      end else begin
        start_r[idx] = 1'b0;
      end
      @(negedge clk);
    end
    start_r[idx] = 1'b0;
    check_eq($sformatf("latency[%0d]", idx), 32'(n), 32'(ndig_of(idx)));
    check_eq($sformatf("done[%0d]", idx), 32'(done_w[idx]), 32'd1);
    check_eq($sformatf("busy_at_done[%0d]", idx), 32'(busy_w[idx]), 32'd0);
    check_eq($sformatf("s[%0d]", idx), 32'(s_w[idx]), 32'(es));
    check_eq($sformatf("c_out[%0d]", idx), 32'(co_w[idx]), 32'(eco));
    check_eq($sformatf("ovf[%0d]", idx), 32'(ov_w[idx]), 32'(eov));
  endtask

  task automatic run_op(input int idx, input logic [15:0] oa, input logic [15:0] ob,
                        input logic oc, input logic os, input bit glitch);
    logic [15:0] es;
    logic        eco, eov;
    model(oa, ob, oc, os, es, eco, eov);
    issue(idx, oa, ob, oc, os);
    wait_done(idx, glitch, es, eco, eov);
    @(negedge clk);
    check_eq($sformatf("done_pulse[%0d]", idx), 32'(done_w[idx]), 32'd0);
    check_eq($sformatf("idle_busy[%0d]", idx), 32'(busy_w[idx]), 32'd0);
    check_eq($sformatf("s_hold[%0d]", idx), 32'(s_w[idx]), 32'(es));
  endtask

  task automatic back_to_back(input int idx);
    logic [15:0] oa, ob, es;
    logic        oc, os, eco, eov;
    oa = 16'($urandom); ob = 16'($urandom);
    oc = 1'($urandom_range(0, 1)); os = 1'($urandom_range(0, 1));
    model(oa, ob, oc, os, es, eco, eov);
    issue(idx, oa, ob, oc, os);
    wait_done(idx, 1'b0, es, eco, eov);
    oa = 16'($urandom); ob = 16'($urandom);
    oc = 1'($urandom_range(0, 1)); os = 1'($urandom_range(0, 1));
    model(oa, ob, oc, os, es, eco, eov);
    a = oa; b = ob; c_in = oc; sub = os;
    start_r[idx] = 1'b1;
    @(negedge clk);
    start_r[idx] = 1'b0;
    scramble();
    wait_done(idx, 1'b0, es, eco, eov);
    @(negedge clk);
    check_eq($sformatf("b2b_done_pulse[%0d]", idx), 32'(done_w[idx]), 32'd0);
  endtask

  task automatic abort_test();
    int seen;
    issue(1, 16'h1234, 16'h4321, 1'b0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_eq("abort_busy", 32'(busy_w[1]), 32'd0);
    check_eq("abort_done", 32'(done_w[1]), 32'd0);
    check_eq("abort_s", 32'(s_w[1]), 32'd0);
    check_eq("abort_c_out", 32'(co_w[1]), 32'd0);
    check_eq("abort_ovf", 32'(ov_w[1]), 32'd0);
    seen = 0;
    repeat (8) begin
      @(negedge clk);
      if (done_w[1] || busy_w[1]) seen++;
    end
    check_eq("abort_no_done", 32'(seen), 32'd0);
  endtask

  logic [15:0] va [5];
  logic [15:0] vb [5];
  logic        vs [5];

  initial begin
    checks   = 0;
    failures = 0;
    va[0] = 16'h1234; vb[0] = 16'h4321; vs[0] = 1'b0;
    va[1] = 16'hFFFF; vb[1] = 16'h0001; vs[1] = 1'b0;
    va[2] = 16'h7FFF; vb[2] = 16'h0001; vs[2] = 1'b0;
    va[3] = 16'h0005; vb[3] = 16'h0007; vs[3] = 1'b1;
    va[4] = 16'h8000; vb[4] = 16'h0001; vs[4] = 1'b1;
    rst = 1'b1;
    for (int i = 0; i < 3; i++) start_r[i] = 1'b0;
    a = '0; b = '0; c_in = 1'b0; sub = 1'b0;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      check_eq($sformatf("rst_busy[%0d]", i), 32'(busy_w[i]), 32'd0);
      check_eq($sformatf("rst_done[%0d]", i), 32'(done_w[i]), 32'd0);
      check_eq($sformatf("rst_s[%0d]", i), 32'(s_w[i]), 32'd0);
      check_eq($sformatf("rst_c_out[%0d]", i), 32'(co_w[i]), 32'd0);
      check_eq($sformatf("rst_ovf[%0d]", i), 32'(ov_w[i]), 32'd0);
    end
    rst = 1'b0;

    for (int idx = 0; idx < 3; idx++) begin
      for (int v = 0; v < 5; v++) run_op(idx, va[v], vb[v], 1'b0, vs[v], 1'b0);
      repeat (8) begin
        run_op(idx, 16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 1)), 1'b0);
      end
      back_to_back(idx);
    end

    run_op(0, 16'h1234, 16'h4321, 1'b1, 1'b0, 1'b1);
    run_op(1, 16'h8000, 16'h0001, 1'b0, 1'b1, 1'b1);

    abort_test();
    run_op(1, 16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
